psum_accum_engine: RTL and testbench

Parametrised read-modify-write partial-sum accumulator for the convolution datapath. It sits between the PE kernel-lane outputs and the psum scratch memory controller. NUM_KERNEL packed lanes are accumulated over cfg_num_pass input-channel passes per output block, and cfg_num_block blocks are stepped by a configurable base-address stride. Memory read latency is a parameter, and first-pass overwrite, error detection and drain are handled by an explicit FSM.

---
 rtl/psum_accum_pkg.sv | 35 +++
 rtl/psum_accum_engine_lane_add.sv | 28 ++
 rtl/psum_accum_engine.sv | 200 ++++++++++++++++++++
 tb/tb_psum_accum_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared state encoding and lane arithmetic for psum_accum_engine.
// Build option PSUM_ACC_SAT_EN: saturating lane adds; otherwise adds wrap.
package psum_accum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Operands arrive sign-extended from a width-bit lane, so the int sum is exact.
  function automatic int lane_add(input int a, input int b, input int width);
    int sum;
`ifdef PSUM_ACC_SAT_EN
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi) sum = hi;
    else if (sum < lo) sum = lo;
`else
    sum = a + b;
    sum = (sum <<< (32 - width)) >>> (32 - width);
`endif
    return sum;
  endfunction

endpackage

// File: rtl/psum_accum_engine_lane_add.sv
// One registered signed lane adder; a first-pass slot bypasses the memory operand.
module psum_lane_add
  import psum_accum_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        first,
  input  logic signed [BIT_WIDTH-1:0] psum,
  input  logic signed [BIT_WIDTH-1:0] mem,
  output logic signed [BIT_WIDTH-1:0] sum
);

  logic signed [BIT_WIDTH-1:0] sum_nxt;

  always_comb begin
    sum_nxt = psum;
    if (!first) sum_nxt = BIT_WIDTH'(lane_add(int'(psum), int'(mem), BIT_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else if (en) sum <= sum_nxt;
  end

endmodule

// File: rtl/psum_accum_engine.sv
// Read-modify-write partial-sum accumulator between PE lanes and psum memory.
// Build option PSUM_ACC_SAT_EN selects saturating lane adds (see psum_accum_pkg).
//
// state | meaning
// IDLE  | reset state, waiting for cfg_start
// FIRST | first pass of a block, psum written without a read
// ACCUM | later pass, memory word + psum written back
// DRAIN | last psum taken, waiting for the pipeline to empty
// DONE  | job finished (o_done) or rejected (o_err)
module psum_accum_engine
  import psum_accum_pkg::*;
#(
  parameter int NUM_KERNEL = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  psum_dat,
  input  logic                             psum_vld,
  input  logic                             cfg_start,
  input  logic [REG_WIDTH-1:0]             cfg_pass_len,
  input  logic [REG_WIDTH-1:0]             cfg_num_pass,
  input  logic [REG_WIDTH-1:0]             cfg_num_block,
  input  logic [ADDR_WIDTH-1:0]            cfg_block_stride,
  output logic [ADDR_WIDTH-1:0]            mem_radd,
  output logic                             mem_rden,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  mem_odat,
  input  logic                             mem_ovld,
  output logic [ADDR_WIDTH-1:0]            mem_wadd,
  output logic                             mem_wren,
  output logic [NUM_KERNEL*BIT_WIDTH-1:0]  mem_idat,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err,
  output logic [REG_WIDTH-1:0]             dbg_elem_cnt,
  output logic [REG_WIDTH-1:0]             dbg_pass_cnt,
  output logic [REG_WIDTH-1:0]             dbg_block_cnt,
  output logic [REG_WIDTH-1:0]             dbg_base_addr
);

  localparam int DW = NUM_KERNEL * BIT_WIDTH;

  state_t state, state_nxt;

  logic [REG_WIDTH-1:0]  pass_len, num_pass, num_block;
  logic [ADDR_WIDTH-1:0] stride, base_addr, elem_addr;
  logic [REG_WIDTH-1:0]  elem_cnt, pass_cnt, block_cnt;

  logic [MEM_DELAY-1:0]  pipe_vld, pipe_first;
  logic [ADDR_WIDTH-1:0] pipe_addr [MEM_DELAY];
  logic [DW-1:0]         pipe_dat  [MEM_DELAY];

  logic start_ok, cfg_bad, accept, end_pass, last_pass, last_block, pipe_busy;
  logic tail_vld, tail_first, tail_write, err_ev;

  assign start_ok   = cfg_start && (state == IDLE || state == DONE);
  assign cfg_bad    = (cfg_pass_len <= REG_WIDTH'(MEM_DELAY + 1)) ||
                      (cfg_num_pass == '0) || (cfg_num_block == '0);
  assign accept     = psum_vld && (state == FIRST || state == ACCUM);
  assign end_pass   = accept && (elem_cnt == pass_len - REG_WIDTH'(1));
  assign last_pass  = (pass_cnt == num_pass - REG_WIDTH'(1));
  assign last_block = (block_cnt == num_block - REG_WIDTH'(1));
  assign elem_addr  = base_addr + ADDR_WIDTH'(elem_cnt);
  assign pipe_busy  = |pipe_vld;

  assign mem_rden = psum_vld && (state == ACCUM);
  assign mem_radd = elem_addr;
  assign o_busy   = (state != IDLE) && (state != DONE);

  assign dbg_elem_cnt  = elem_cnt;
  assign dbg_pass_cnt  = pass_cnt;
  assign dbg_block_cnt = block_cnt;
  assign dbg_base_addr = REG_WIDTH'(base_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (cfg_start) state_nxt = cfg_bad ? DONE : FIRST;
      FIRST, ACCUM: begin
        if (end_pass) begin
          if (!last_pass)      state_nxt = ACCUM;
          else if (last_block) state_nxt = DRAIN;
          else                 state_nxt = FIRST;
        end
      end
      // The slot leaving the last stage is written this cycle, so it is not "in flight".
      DRAIN: if (!pipe_busy) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_len  <= '0;
      num_pass  <= '0;
      num_block <= '0;
      stride    <= '0;
      elem_cnt  <= '0;
      pass_cnt  <= '0;
      block_cnt <= '0;
      base_addr <= '0;
    end else if (start_ok) begin
      pass_len  <= cfg_pass_len;
      num_pass  <= cfg_num_pass;
      num_block <= cfg_num_block;
      stride    <= cfg_block_stride;
      elem_cnt  <= '0;
      pass_cnt  <= '0;
      block_cnt <= '0;
      base_addr <= '0;
    end else if (accept) begin
      if (end_pass) begin
        elem_cnt <= '0;
        if (last_pass) begin
          pass_cnt  <= '0;
          block_cnt <= block_cnt + REG_WIDTH'(1);
          base_addr <= base_addr + stride;
        end else begin
          pass_cnt <= pass_cnt + REG_WIDTH'(1);
        end
      end else begin
        elem_cnt <= elem_cnt + REG_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld   <= '0;
      pipe_first <= '0;
      for (int i = 0; i < MEM_DELAY; i++) begin
        pipe_addr[i] <= '0;
        pipe_dat[i]  <= '0;
      end
    end else begin
      pipe_vld[0]   <= accept;
      pipe_first[0] <= (state == FIRST);
      pipe_addr[0]  <= elem_addr;
      pipe_dat[0]   <= psum_dat;
      for (int i = 1; i < MEM_DELAY; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_dat[i]   <= pipe_dat[i-1];
      end
    end
  end

  // An ACCUM slot without its read data is dropped rather than written with garbage.
  assign tail_vld   = pipe_vld[MEM_DELAY-1];
  assign tail_first = pipe_first[MEM_DELAY-1];
  assign tail_write = tail_vld && (tail_first || mem_ovld);
  assign err_ev     = (tail_vld && !tail_first && !mem_ovld) ||
                      (mem_ovld && !(tail_vld && !tail_first));

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    localparam int LSB = lane_lsb(k, BIT_WIDTH);
    psum_lane_add #(.BIT_WIDTH(BIT_WIDTH)) u_add (
      .clk   (clk),
      .rst   (rst),
      .en    (tail_write),
      .first (tail_first),
      .psum  (pipe_dat[MEM_DELAY-1][LSB +: BIT_WIDTH]),
      .mem   (mem_odat[LSB +: BIT_WIDTH]),
      .sum   (mem_idat[LSB +: BIT_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wren <= 1'b0;
      mem_wadd <= '0;
    end else begin
      mem_wren <= tail_write;
      if (tail_write) mem_wadd <= pipe_addr[MEM_DELAY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else if (start_ok) begin
      o_done <= 1'b0;
      o_err  <= cfg_bad;
    end else begin
      if (state == DRAIN && !pipe_busy) o_done <= 1'b1;
      if (err_ev) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_accum_engine.sv
// Bench for psum_accum_engine: jobs driven against a per-address accumulation
// model; a forked monitor pops expected writes as the DUT issues them.
module tb_psum_accum_engine;
  localparam int NK   = 4;
  localparam int BW   = 8;
  localparam int AW   = 32;
  localparam int RW   = 32;
  localparam int MD   = 2;
  localparam int DW   = NK * BW;
  localparam int HALF = 1 << (BW - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] psum_dat = '0;
  logic          psum_vld = 1'b0;
  logic          cfg_start = 1'b0;
  logic [RW-1:0] cfg_pass_len = '0, cfg_num_pass = '0, cfg_num_block = '0;
  logic [AW-1:0] cfg_block_stride = '0;
  logic [AW-1:0] mem_radd, mem_wadd;
  logic          mem_rden, mem_wren, mem_ovld;
  logic [DW-1:0] mem_odat, mem_idat;
  logic          o_busy, o_done, o_err;
  logic [RW-1:0] dbg_elem_cnt, dbg_pass_cnt, dbg_block_cnt, dbg_base_addr;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, rd_cnt = 0, wr_cnt = 0, last_wren_cyc = 0;
  int  ref_val [256][NK];

  logic [DW-1:0] mem     [256] = '{default: '0};
  logic          rsp_vld [MD]  = '{default: 1'b0};
  logic [DW-1:0] rsp_dat [MD]  = '{default: '0};
  logic          drop_en = 1'b0;
  logic [AW-1:0] drop_target = '0;

  psum_accum_engine #(
    .NUM_KERNEL(NK), .BIT_WIDTH(BW), .ADDR_WIDTH(AW), .REG_WIDTH(RW), .MEM_DELAY(MD)
  ) dut (
    .clk(clk), .rst(rst), .psum_dat(psum_dat), .psum_vld(psum_vld),
    .cfg_start(cfg_start), .cfg_pass_len(cfg_pass_len), .cfg_num_pass(cfg_num_pass),
    .cfg_num_block(cfg_num_block), .cfg_block_stride(cfg_block_stride),
    .mem_radd(mem_radd), .mem_rden(mem_rden), .mem_odat(mem_odat), .mem_ovld(mem_ovld),
    .mem_wadd(mem_wadd), .mem_wren(mem_wren), .mem_idat(mem_idat),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .dbg_elem_cnt(dbg_elem_cnt), .dbg_pass_cnt(dbg_pass_cnt),
    .dbg_block_cnt(dbg_block_cnt), .dbg_base_addr(dbg_base_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory with a fixed read latency; optionally withholds one response.
  always @(posedge clk) begin
    rsp_vld[0] <= mem_rden && !(drop_en && mem_radd == drop_target);
    rsp_dat[0] <= mem[mem_radd[7:0]];
    for (int i = 1; i < MD; i++) begin
      rsp_vld[i] <= rsp_vld[i-1];
      rsp_dat[i] <= rsp_dat[i-1];
    end
    if (mem_wren) mem[mem_wadd[7:0]] <= mem_idat;
  end
  assign mem_ovld = rsp_vld[MD-1];
  assign mem_odat = rsp_dat[MD-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int fold(input int s);
`ifdef PSUM_ACC_SAT_EN
    if (s > HALF - 1) return HALF - 1;
    if (s < -HALF) return -HALF;
    return s;
`else
    return ((s + HALF) % (2 * HALF) + 2 * HALF) % (2 * HALF) - HALF;
`endif
  endfunction

  // mode 0: random, 1: directed ramp, 2: overflow corners
  function automatic int gen_val(input int mode, input int p, input int e, input int l);
    int t0 [NK];
    int t1 [NK];
    t0 = '{127, -128, 100, -100};
    t1 = '{1, -1, 100, -100};
    if (mode == 1) return (p == 0) ? e + 1 : (e + 1) * 10;
    if (mode == 2) return (p == 0) ? t0[l] : t1[l];
    return int'($urandom_range(0, 2 * HALF - 1)) - HALF;
  endfunction

  task automatic issue(input int addr, input int p, input int e, input int mode, input bit keep);
    logic [DW-1:0] din;
    logic [DW-1:0] dexp;
    int v;
    din = '0;
    dexp = '0;
    for (int l = 0; l < NK; l++) begin
      v = gen_val(mode, p, e, l);
      din[l*BW +: BW] = BW'(v);
      ref_val[addr][l] = (p == 0) ? v : fold(ref_val[addr][l] + v);
      dexp[l*BW +: BW] = BW'(ref_val[addr][l]);
    end
    psum_dat = din;
    psum_vld = 1'b1;
    if (keep) exp_q.push_back('{addr: AW'(addr), data: dexp, cyc: cyc + MD + 1});
    @(posedge clk); #1;
    psum_vld = 1'b0;
  endtask

  task automatic start(input int pl, input int np, input int nb, input int stride);
    cfg_pass_len = RW'(pl);
    cfg_num_pass = RW'(np);
    cfg_num_block = RW'(nb);
    cfg_block_stride = AW'(stride);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_job(input int pl, input int np, input int nb, input int stride,
                         input int mode, input int drop_a);
    int rd0, n_acc, n, a;
    start(pl, np, nb, stride);
    rd0 = rd_cnt;
    n_acc = 0;
    for (int b = 0; b < nb; b++)
      for (int p = 0; p < np; p++)
        for (int e = 0; e < pl; e++) begin
          if (mode == 0 && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          a = b * stride + e;
          if (p > 0) n_acc++;
          issue(a, p, e, mode, !(p > 0 && a == drop_a));
        end
    n = 0;
    while (!o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", o_done, 1'b1);
    chk("done_after_last_wren", cyc, last_wren_cyc + 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("read_count", rd_cnt - rd0, n_acc);
    chk("busy_clear", o_busy, 1'b0);
  endtask

  task automatic bad_job(input int pl, input int np, input int nb);
    int w0, r0;
    start(pl, np, nb, 16);
    w0 = wr_cnt;
    r0 = rd_cnt;
    repeat (6) begin
      psum_dat = DW'($urandom);
      psum_vld = 1'b1;
      @(posedge clk); #1;
    end
    psum_vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bad_err", o_err, 1'b1);
    chk("bad_done", o_done, 1'b0);
    chk("bad_busy", o_busy, 1'b0);
    chk("bad_traffic", (wr_cnt - w0) + (rd_cnt - r0), 0);
  endtask

  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem_rden === 1'b1) rd_cnt++;
      if (mem_wren === 1'b1) begin
        last_wren_cyc = cyc;
        wr_cnt++;
        chk("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("wr_addr", mem_wadd, w.addr);
          chk("wr_data", mem_idat, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_wren"}, mem_wren, 1'b0);
    chk({tag, "_rden"}, mem_rden, 1'b0);
    chk({tag, "_wadd"}, mem_wadd, '0);
    chk({tag, "_radd"}, mem_radd, '0);
    chk({tag, "_idat"}, mem_idat, '0);
    chk({tag, "_counters"}, {dbg_elem_cnt | dbg_pass_cnt, dbg_block_cnt | dbg_base_addr}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    fork
      monitor();
    join_none

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    run_job(4, 2, 1, 0, 1, -1);
    chk("ramp_no_err", o_err, 1'b0);
    run_job(4, 1, 2, 16, 1, -1);
    run_job(4, 2, 1, 0, 2, -1);
    repeat (3) run_job($urandom_range(4, 8), $urandom_range(1, 3), $urandom_range(1, 3), 16, 0, -1);
    chk("random_no_err", o_err, 1'b0);

    bad_job(3, 2, 1);
    bad_job(5, 0, 1);
    bad_job(5, 1, 0);

    drop_target = AW'(2);
    drop_en = 1'b1;
    run_job(4, 2, 1, 0, 1, 2);
    drop_en = 1'b0;
    chk("drop_err", o_err, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drop_err_sticky", o_err, 1'b1);

    run_job(5, 2, 1, 0, 0, -1);
    chk("err_cleared_by_start", o_err, 1'b0);

    start(6, 2, 1, 0);
    for (int e = 0; e < 6; e++) issue(e, 0, e, 0, 1'b1);
    for (int e = 0; e < 3; e++) issue(e, 1, e, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    w0 = wr_cnt;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("no_wren_after_reset", wr_cnt, w0);
    check_all_zero("midjob_reset");

    run_job(4, 2, 2, 16, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
